// File: rtl/lcm_mcmd_parser.sv
// Multi-command local-management parser: decodes read/write command beats addressed
// to LMID and queues them in a small FIFO presented on a valid/ready command port.
module lcm_mcmd_parser #(
    parameter string       PLATFORM   = "Xilinx-OpenBox-S4",
    parameter logic [7:0]  LMID       = 8'd3,
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_CMDS   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [133:0]      in_lcm_data,
    input  logic              in_lcm_data_wr,
    input  logic              in_lcm_data_valid,
    input  logic              in_lcm_data_valid_wr,
    output logic              in_lcm_data_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rd,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_data,
    output logic [3:0]        err_status
);
    // Command port handshake: an entry transfers on any edge where cmd_valid && cmd_ready;
    // while cmd_valid is high and cmd_ready low, cmd_rd/cmd_addr/cmd_data are held stable.

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int CNT_W   = $clog2(MAX_CMDS + 1);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam bit unused_platform = (PLATFORM != "");

    typedef enum logic [1:0] {IDLE, RD, WR, DROP} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [OCC_W-1:0]   occ, occ_nxt;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head_entry, push_entry;

    logic       is_head, is_body, is_tail;
    logic       push, push_ok, pop, full;
    logic       cnt_clr, decode_head;
    logic [3:0] err_set;
    logic       unused_inputs;

    assign unused_inputs = ^{in_lcm_data, in_lcm_data_valid, in_lcm_data_valid_wr, unused_platform};

    assign is_head = (in_lcm_data[133:132] == 2'b01);
    assign is_tail = (in_lcm_data[133:132] == 2'b10);
    assign is_body = (in_lcm_data[133:132] == 2'b11) || is_tail;

    assign full    = (occ == OCC_W'(FIFO_DEPTH));
    assign pop     = cmd_valid && cmd_ready;
    assign push_ok = push && (!full || pop);
    assign occ_nxt = occ + OCC_W'(push_ok) - OCC_W'(pop);

    assign push_entry = {(state == RD), in_lcm_data[120 +: ADDR_W],
                         (state == RD) ? {DATA_W{1'b0}} : in_lcm_data[56 +: DATA_W]};

    always_comb begin
        state_nxt   = state;
        push        = 1'b0;
        cnt_clr     = 1'b0;
        decode_head = 1'b0;
        err_set     = 4'b0000;
        if (in_lcm_data_wr) begin
            if (is_head) begin
                decode_head = 1'b1;
                if (state == RD || state == WR) err_set[1] = 1'b1;
            end else if (is_body) begin
                case (state)
                    IDLE: err_set[0] = 1'b1;
                    RD, WR: begin
                        if (cnt == CNT_W'(MAX_CMDS)) err_set[2] = 1'b1;
                        else                         push       = 1'b1;
                        if (is_tail) state_nxt = IDLE;
                    end
                    DROP: if (is_tail) state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
            end
        end
        // A head beat restarts decoding from any state.
        if (decode_head) begin
            cnt_clr = 1'b1;
            if (in_lcm_data[47:40] == LMID) state_nxt = in_lcm_data[48] ? RD : WR;
            else                            state_nxt = DROP;
        end
        if (push && full && !pop) err_set[3] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            occ               <= '0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            err_status        <= 4'b0000;
            in_lcm_data_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            err_status <= err_status | err_set;
            occ        <= occ_nxt;
            if (cnt_clr)   cnt <= '0;
            else if (push) cnt <= cnt + 1'b1;
            if (push_ok)   wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            // One entry stays in reserve for the beat upstream may send after ready falls.
            in_lcm_data_ready <= (occ_nxt <= OCC_W'(FIFO_DEPTH - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    assign head_entry = mem[rd_ptr];
    assign cmd_valid  = (occ != '0);
    assign cmd_rd     = cmd_valid & head_entry[ENTRY_W-1];
    assign cmd_addr   = cmd_valid ? head_entry[DATA_W +: ADDR_W] : '0;
    assign cmd_data   = cmd_valid ? head_entry[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_lcm_mcmd_parser.sv
// Bench for lcm_mcmd_parser: directed vector tables, hand-written corner sequences and
// a randomized run compared against a queue-based reference model.
module tb_lcm_mcmd_parser;
    localparam int DEPTH = 4;
    localparam int MAXC  = 16;

    logic         clk = 1'b0;
    logic         rst_n, rst2_n;
    logic [133:0] in_lcm_data;
    logic         in_lcm_data_wr, in_lcm_data_valid, in_lcm_data_valid_wr;
    logic         in_lcm_data_ready, cmd_valid, cmd_ready, cmd_rd;
    logic [7:0]   cmd_addr;
    logic [63:0]  cmd_data;
    logic [3:0]   err_status;
    logic         rdy2, valid2, rd2;
    logic [7:0]   addr2;
    logic [63:0]  data2;
    logic [3:0]   err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcm_mcmd_parser #(.LMID(8'd3), .ADDR_W(8), .DATA_W(64), .FIFO_DEPTH(DEPTH), .MAX_CMDS(MAXC)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_lcm_data(in_lcm_data), .in_lcm_data_wr(in_lcm_data_wr),
        .in_lcm_data_valid(in_lcm_data_valid), .in_lcm_data_valid_wr(in_lcm_data_valid_wr),
        .in_lcm_data_ready(in_lcm_data_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .err_status(err_status));

    lcm_mcmd_parser #(.LMID(8'd3), .ADDR_W(8), .DATA_W(64), .FIFO_DEPTH(DEPTH), .MAX_CMDS(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .in_lcm_data(in_lcm_data), .in_lcm_data_wr(in_lcm_data_wr),
        .in_lcm_data_valid(in_lcm_data_valid), .in_lcm_data_valid_wr(in_lcm_data_valid_wr),
        .in_lcm_data_ready(rdy2), .cmd_valid(valid2), .cmd_ready(cmd_ready),
        .cmd_rd(rd2), .cmd_addr(addr2), .cmd_data(data2), .err_status(err2));

    typedef struct {
        logic        wr;
        logic [1:0]  kind;
        logic        rdf;
        logic [7:0]  id;
        logic [7:0]  addr;
        logic [63:0] data;
        logic        rdy;
        logic        e_valid;
        logic        e_rd;
        logic [7:0]  e_addr;
        logic [63:0] e_data;
        logic        e_ready;
        logic [3:0]  e_err;
    } vec_t;

    vec_t vq[$];

    // Reference model: the FIFO as a queue of {rd, addr, data}, plus packet mode and count.
    logic [72:0] exp_q[$];
    int          m_mode;
    int          m_cnt;
    logic [3:0]  m_err;

    function automatic vec_t mkv(input logic w, input logic [1:0] k, input logic rf, input logic [7:0] id,
                                 input logic [7:0] a, input logic [63:0] d, input logic r,
                                 input logic ev, input logic erd, input logic [7:0] ea,
                                 input logic [63:0] ed, input logic erdy, input logic [3:0] ee);
        vec_t v;
        v.wr = w; v.kind = k; v.rdf = rf; v.id = id; v.addr = a; v.data = d; v.rdy = r;
        v.e_valid = ev; v.e_rd = erd; v.e_addr = ea; v.e_data = ed; v.e_ready = erdy; v.e_err = ee;
        return v;
    endfunction

    function automatic logic [133:0] beat(input logic [1:0] k, input logic rf, input logic [7:0] id,
                                          input logic [7:0] a, input logic [63:0] d);
        logic [133:0] b;
        b = '0;
        b[133:132] = k;
        b[48]      = rf;
        b[47:40]   = id;
        b[127:120] = a;
        b[119:56]  = d;
        return b;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [133:0] b, input logic r);
        in_lcm_data_wr = w;
        in_lcm_data    = b;
        cmd_ready      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 80'(cmd_valid), 80'd0);
        check({tag, "_rd"},    80'(cmd_rd), 80'd0);
        check({tag, "_addr"},  80'(cmd_addr), 80'd0);
        check({tag, "_data"},  80'(cmd_data), 80'd0);
        check({tag, "_ready"}, 80'(in_lcm_data_ready), 80'd1);
        check({tag, "_err"},   80'(err_status), 80'd0);
    endtask

    task automatic do_reset();
        in_lcm_data_wr = 1'b0;
        in_lcm_data    = '0;
        cmd_ready      = 1'b0;
        rst_n          = 1'b0;
        rst2_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        exp_q.delete();
        m_mode = 0;
        m_cnt  = 0;
        m_err  = 4'b0000;
    endtask

    // Modes: 0 idle, 1 read packet, 2 write packet, 3 dropping a foreign packet.
    task automatic model_step(input logic w, input logic [1:0] k, input logic rf, input logic [7:0] id,
                              input logic [7:0] a, input logic [63:0] d, input logic r);
        logic        pop, do_push;
        logic [72:0] ent;
        pop     = (exp_q.size() > 0) && r;
        do_push = 1'b0;
        ent     = '0;
        if (w) begin
            if (k == 2'b01) begin
                if (m_mode == 1 || m_mode == 2) m_err[1] = 1'b1;
                if (id == 8'd3) begin
                    m_mode = rf ? 1 : 2;
                    m_cnt  = 0;
                end else begin
                    m_mode = 3;
                end
            end else if (k == 2'b11 || k == 2'b10) begin
                if (m_mode == 0) begin
                    m_err[0] = 1'b1;
                end else if (m_mode == 1 || m_mode == 2) begin
                    if (m_cnt == MAXC) begin
                        m_err[2] = 1'b1;
                    end else begin
                        m_cnt++;
                        do_push = 1'b1;
                        ent = (m_mode == 1) ? {1'b1, a, 64'd0} : {1'b0, a, d};
                    end
                end
                if (k == 2'b10) m_mode = 0;
            end
        end
        if (do_push && exp_q.size() == DEPTH && !pop) begin
            m_err[3] = 1'b1;
            do_push  = 1'b0;
        end
        if (pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(ent);
    endtask

    initial begin
        logic [1:0]  k;
        logic        w, rf, r;
        logic [7:0]  id, a;
        logic [63:0] d;
        int          sel;

        in_lcm_data_valid    = 1'b0;
        in_lcm_data_valid_wr = 1'b0;
        do_reset();
        check_reset_values("reset");

        // Write x3, read tail-only, foreign ID followed by a good packet.
        vq.push_back(mkv(1, 2'b01, 0, 3, 0, 0,          0, 0, 0, 0, 0,     1, 0));
        vq.push_back(mkv(1, 2'b11, 0, 3, 1, 64'h11,     0, 1, 0, 1, 64'h11, 1, 0));
        vq.push_back(mkv(1, 2'b11, 0, 3, 2, 64'h22,     0, 1, 0, 1, 64'h11, 1, 0));
        vq.push_back(mkv(1, 2'b10, 0, 3, 3, 64'h33,     0, 1, 0, 1, 64'h11, 0, 0));
        vq.push_back(mkv(0, 2'b00, 0, 0, 0, 0,          1, 1, 0, 2, 64'h22, 1, 0));
        vq.push_back(mkv(0, 2'b00, 0, 0, 0, 0,          1, 1, 0, 3, 64'h33, 1, 0));
        vq.push_back(mkv(0, 2'b00, 0, 0, 0, 0,          1, 0, 0, 0, 0,     1, 0));
        vq.push_back(mkv(1, 2'b01, 1, 3, 0, 0,          0, 0, 0, 0, 0,     1, 0));
        vq.push_back(mkv(1, 2'b10, 0, 3, 7, 64'hdead,   0, 1, 1, 7, 0,     1, 0));
        vq.push_back(mkv(0, 2'b00, 0, 0, 0, 0,          1, 0, 0, 0, 0,     1, 0));
        vq.push_back(mkv(1, 2'b01, 0, 5, 0, 0,          0, 0, 0, 0, 0,     1, 0));
        vq.push_back(mkv(1, 2'b11, 0, 5, 1, 64'h1,      0, 0, 0, 0, 0,     1, 0));
        vq.push_back(mkv(1, 2'b10, 0, 5, 2, 64'h2,      0, 0, 0, 0, 0,     1, 0));
        vq.push_back(mkv(1, 2'b01, 0, 3, 0, 0,          0, 0, 0, 0, 0,     1, 0));
        vq.push_back(mkv(1, 2'b10, 0, 3, 9, 64'h99,     0, 1, 0, 9, 64'h99, 1, 0));
        vq.push_back(mkv(0, 2'b00, 0, 0, 0, 0,          1, 0, 0, 0, 0,     1, 0));

        foreach (vq[i]) begin
            step(vq[i].wr, beat(vq[i].kind, vq[i].rdf, vq[i].id, vq[i].addr, vq[i].data), vq[i].rdy);
            check($sformatf("vec%0d_valid", i), 80'(cmd_valid), 80'(vq[i].e_valid));
            if (vq[i].e_valid) begin
                check($sformatf("vec%0d_rd", i),   80'(cmd_rd),   80'(vq[i].e_rd));
                check($sformatf("vec%0d_addr", i), 80'(cmd_addr), 80'(vq[i].e_addr));
                check($sformatf("vec%0d_data", i), 80'(cmd_data), 80'(vq[i].e_data));
            end
            check($sformatf("vec%0d_ready", i), 80'(in_lcm_data_ready), 80'(vq[i].e_ready));
            check($sformatf("vec%0d_err", i),   80'(err_status),        80'(vq[i].e_err));
        end

        // Back-pressure: six beats into a stalled FIFO of depth 4.
        do_reset();
        step(1, beat(2'b01, 0, 3, 0, 0), 0);
        for (int n = 1; n <= 6; n++) begin
            step(1, beat((n == 6) ? 2'b10 : 2'b11, 0, 3, 8'(n), 64'(n * 16)), 0);
            check($sformatf("bp_ready_%0d", n), 80'(in_lcm_data_ready), 80'(n < 3));
            check($sformatf("bp_err3_%0d", n),  80'(err_status[3]),     80'(n >= 5));
        end
        for (int n = 1; n <= 4; n++) begin
            check($sformatf("bp_valid_%0d", n), 80'(cmd_valid), 80'd1);
            check($sformatf("bp_addr_%0d", n),  80'(cmd_addr),  80'(n));
            step(0, '0, 1);
        end
        check("bp_empty", 80'(cmd_valid), 80'd0);
        check("bp_ready_back", 80'(in_lcm_data_ready), 80'd1);

        // Orphan body beat, then a head arriving before the tail.
        do_reset();
        step(1, beat(2'b10, 0, 3, 1, 1), 0);
        check("orphan_err", 80'(err_status), 80'h1);
        check("orphan_valid", 80'(cmd_valid), 80'd0);
        step(1, beat(2'b01, 0, 3, 0, 0), 0);
        step(1, beat(2'b11, 0, 3, 8'h0a, 64'ha1), 0);
        step(1, beat(2'b01, 0, 3, 0, 0), 0);
        check("trunc_err", 80'(err_status), 80'h3);
        step(1, beat(2'b10, 0, 3, 8'h0b, 64'hb2), 0);
        check("trunc_cmd0", 80'({cmd_valid, cmd_rd, cmd_addr, cmd_data}), 80'({1'b1, 1'b0, 8'h0a, 64'ha1}));
        step(0, '0, 1);
        check("trunc_cmd1", 80'({cmd_valid, cmd_rd, cmd_addr, cmd_data}), 80'({1'b1, 1'b0, 8'h0b, 64'hb2}));
        step(0, '0, 1);
        check("trunc_empty", 80'(cmd_valid), 80'd0);

        // Command-count limit on the MAX_CMDS = 2 instance.
        do_reset();
        step(1, beat(2'b01, 0, 3, 0, 0), 0);
        step(1, beat(2'b11, 0, 3, 1, 64'h5), 0);
        step(1, beat(2'b11, 0, 3, 2, 64'h6), 0);
        check("cnt_err_before", 80'(err2), 80'h0);
        step(1, beat(2'b10, 0, 3, 3, 64'h7), 0);
        check("cnt_err_after", 80'(err2), 80'h4);
        check("cnt_err_dut1", 80'(err_status), 80'h0);
        check("cnt_cmd0", 80'({valid2, addr2, data2}), 80'({1'b1, 8'd1, 64'h5}));
        step(0, '0, 1);
        check("cnt_cmd1", 80'({valid2, addr2, data2}), 80'({1'b1, 8'd2, 64'h6}));
        step(0, '0, 1);
        check("cnt_empty", 80'(valid2), 80'd0);

        // Reset in the middle of a packet.
        do_reset();
        step(1, beat(2'b01, 0, 3, 0, 0), 0);
        step(1, beat(2'b11, 0, 3, 1, 64'h1), 0);
        check("mid_valid_pre", 80'(cmd_valid), 80'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, beat(2'b11, 0, 3, 2, 64'h2), 0);
        check("mid_after_err", 80'(err_status), 80'h1);
        check("mid_after_valid", 80'(cmd_valid), 80'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            w   = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 9);
            k   = (sel < 2) ? 2'b01 : (sel < 6) ? 2'b11 : (sel < 8) ? 2'b10 : (sel == 8) ? 2'b00 : 2'b01;
            rf  = 1'($urandom_range(0, 1));
            id  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd3;
            a   = 8'($urandom_range(0, 255));
            d   = {$urandom, $urandom};
            r   = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            model_step(w, k, rf, id, a, d, r);
            step(w, beat(k, rf, id, a, d), r);
            check("rnd_valid", 80'(cmd_valid), 80'(exp_q.size() > 0));
            if (exp_q.size() > 0) check("rnd_cmd", 80'({cmd_rd, cmd_addr, cmd_data}), 80'(exp_q[0]));
            check("rnd_ready", 80'(in_lcm_data_ready), 80'((DEPTH - exp_q.size()) >= 2));
            check("rnd_err", 80'(err_status), 80'(m_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcm_mcmd_parser.md
# lcm_mcmd_parser

Parametrised local-management command parser, successor to the single-command LCM parser. Decodes management packets addressed to this module ID. A packet may carry several read or write commands, one per body beat. Decoded commands are buffered in an internal FIFO and presented on a valid/ready command port to the register file. The block sits between the LCM packet path and the module's register bank, and applies back-pressure upstream through `in_lcm_data_ready`.

## Interface
Parameters:
- `PLATFORM`, "Xilinx-OpenBox-S4": platform tag; no functional effect.
- `LMID`, 8'd3: module ID. Packets whose header ID differs are discarded.
- `ADDR_W`, 8: register address width, 1..8. Taken from the low bits of the beat's [127:120].
- `DATA_W`, 64: register data width, 1..64. Taken from the low bits of the beat's [119:56].
- `FIFO_DEPTH`, 4: command FIFO depth. Power of 2, ≥ 2.
- `MAX_CMDS`, 16: maximum command beats accepted per packet.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_lcm_data` in 134: packet beat. [133:132] = 01 head, 11 middle, 10 tail. In the head beat, [48] = 1 for read, 0 for write, and [47:40] = module ID.
- `in_lcm_data_wr` in 1: beat strobe. A beat is processed only when this is 1.
- `in_lcm_data_valid` in 1: end-of-packet validity. Accepted; not used for decode.
- `in_lcm_data_valid_wr` in 1: strobe for `in_lcm_data_valid`. Accepted; not used for decode.
- `in_lcm_data_ready` out 1: registered. 1 when the FIFO has at least 2 free entries.
- `cmd_valid` out 1: the FIFO head holds a command.
- `cmd_ready` in 1: consumer accepts the head command.
- `cmd_rd` out 1: 1 for a read, 0 for a write.
- `cmd_addr` out ADDR_W: register address.
- `cmd_data` out DATA_W: write value; 0 for reads.
- `err_status` out 4: sticky error bits. [0] orphan body beat; [1] truncated packet; [2] command-count overflow; [3] FIFO overflow.

## Operation
- **States:** IDLE, RD, WR, DROP. Reset state is IDLE.
- **IDLE, head beat:**
  - ID == LMID: go to RD if [48] = 1, else WR. Clear the per-packet counter.
  - ID ≠ LMID: go to DROP.
- **IDLE, body beat (11 or 10):** ignore it and set `err_status[0]`.
- **RD/WR, body beat (11 or 10):** push one command to the FIFO.
  - Fields: `cmd_rd` = (state == RD); `cmd_addr` = [ADDR_W+119:120]; `cmd_data` = [DATA_W+55:56] in WR, 0 in RD.
  - The per-packet counter increments on each push.
  - A tail beat (10) returns to IDLE after its push.
  - The head beat itself carries no command.
- **Command-count limit:** once the counter equals MAX_CMDS, further body beats are not pushed and set `err_status[2]`. The state machine stays in RD/WR until the tail.
- **RD/WR, new head beat (missing tail):** set `err_status[1]` and decode the new header as if the machine were in IDLE.
- **DROP:** discard all beats. The tail beat returns to IDLE. A head beat in DROP is decoded as in IDLE.
- **FIFO full:** a push attempted while the FIFO is full drops the command and sets `err_status[3]`. The state machine advances normally.
- **FIFO pop:** on `cmd_valid && cmd_ready`.
  - A push and a pop in the same cycle are both performed, and the occupancy is unchanged.
  - When full, a simultaneous push and pop succeeds; no overflow is flagged.
- **Error bits:** clear only on reset.

## Timing
- **Reset values:** state IDLE; FIFO empty; `cmd_valid` 0; `cmd_rd` 0; `cmd_addr` 0; `cmd_data` 0; `err_status` 0; `in_lcm_data_ready` 1.
- **Decode latency:** a body beat accepted in cycle N gives `cmd_valid` = 1 with that command in cycle N+1, if the FIFO was empty. Otherwise the command is presented after the earlier entries are popped, in order.
- **Command outputs:** hold stable while `cmd_valid && !cmd_ready`.
- **Back-pressure:** `in_lcm_data_ready` is computed from the post-edge occupancy, so it deasserts in the cycle after occupancy reaches FIFO_DEPTH−1. Upstream may send one more beat after ready falls; the reserved entry absorbs it.
- **Reset mid-packet:** the FIFO contents and the partial packet are discarded. Beats after reset release are decoded from IDLE, so the remaining body beats of the interrupted packet flag `err_status[0]`.

## Test plan
- **Write, 3 commands:** LMID = 3. Head (ID 3, [48] = 0), then body beats (01, 0x11), (02, 0x22), tail (03, 0x33). Required: three commands, in order (`cmd_rd` = 0, addr 1/2/3, data 0x11/0x22/0x33), with first `cmd_valid` one cycle after the first body beat.
- **Read, tail only:** head [48] = 1, then tail addr 0x07. Required: one command, `cmd_rd` = 1, `cmd_addr` = 7, `cmd_data` = 0.
- **Foreign ID:** header ID 5, two body beats. Required: no commands, `err_status` = 0. A following valid packet with ID 3 decodes normally.
- **Back-pressure:** FIFO_DEPTH = 4, `cmd_ready` = 0, six body beats sent regardless of ready. Required:
  - ready falls after the 3rd push;
  - the 4th command is stored;
  - the 5th and 6th are dropped and `err_status[3]` = 1;
  - popping returns addresses 1..4.
- **Protocol faults:**
  - Body beat in IDLE → `err_status[0]`.
  - A head beat during WR → `err_status[1]`, and the new packet decodes correctly.
  - With MAX_CMDS = 2 and three body beats → two commands and `err_status[2]`.
- **Reset mid-packet:** assert `rst_n` = 0 after the head and one body beat. Required: all outputs return to reset values and the FIFO is empty.
